// File: rtl/pp_reduction_sequencer.sv
// Folds a stream of partial products through one external 5:2 tree, feeding S/H back as operands 0/1.
// Optional PPR_PERF_CNT_EN adds saturating stall/pass counters.
module pp_reduction_sequencer #(
    parameter int W       = 44,
    parameter int NPP_MAX = 16,
    parameter int CW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_npp,
    input  logic          pp_in_valid,
    output logic          pp_in_ready,
    input  logic [W-1:0]  pp_in_data,
    output logic [W-1:0]  tree_d0,
    output logic [W-1:0]  tree_d1,
    output logic [W-1:0]  tree_d2,
    output logic [W-1:0]  tree_d3,
    output logic [W-1:0]  tree_d4,
    input  logic [W-1:0]  tree_s,
    input  logic [W-1:0]  tree_h,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_s,
    output logic [W-1:0]  res_h
`ifdef PPR_PERF_CNT_EN
   ,output logic [15:0]   perf_stall,
    output logic [15:0]   perf_pass
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, REDUCE, OUT} state_t;

    state_t               state, state_n;
    logic [4:0][W-1:0]    opnd;
    logic [CW-1:0]        rem;
    logic [CW-1:0]        need;
    logic [CW-1:0]        npp_clamp;
    logic [2:0]           slot;
    logic [2:0]           wr_idx;
    logic                 first;
    logic                 pp_fire;
    logic                 last_pass;

    assign tree_d0 = opnd[0];
    assign tree_d1 = opnd[1];
    assign tree_d2 = opnd[2];
    assign tree_d3 = opnd[3];
    assign tree_d4 = opnd[4];

    // First pass takes five fresh operands; later passes lose two slots to the fed-back S/H.
    always_comb begin
        need = '0;
        if (first) need = (rem < CW'(5)) ? rem : CW'(5);
        else       need = (rem < CW'(3)) ? rem : CW'(3);
    end

    assign npp_clamp = (req_npp > CW'(NPP_MAX)) ? CW'(NPP_MAX) : req_npp;
    assign wr_idx    = first ? slot : slot + 3'd2;
    assign pp_fire   = pp_in_valid & pp_in_ready;
    assign last_pass = (rem == need);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        req_ready   = 1'b0;
        pp_in_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = (req_npp == '0) ? OUT : LOAD;
            end
            LOAD: begin
                pp_in_ready = (CW'(slot) < need);
                if (pp_in_valid && pp_in_ready && (CW'(slot) + CW'(1) == need))
                    state_n = REDUCE;
            end
            REDUCE: state_n = last_pass ? OUT : LOAD;
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd  <= '0;
            rem   <= '0;
            slot  <= '0;
            first <= 1'b0;
            res_s <= '0;
            res_h <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    rem   <= npp_clamp;
                    first <= 1'b1;
                    slot  <= '0;
                    opnd  <= '0;
                    if (req_npp == '0) begin
                        res_s <= '0;
                        res_h <= '0;
                    end
                end
                LOAD: if (pp_fire) begin
                    slot <= slot + 3'd1;
                    case (wr_idx)
                        3'd0:    opnd[0] <= pp_in_data;
                        3'd1:    opnd[1] <= pp_in_data;
                        3'd2:    opnd[2] <= pp_in_data;
                        3'd3:    opnd[3] <= pp_in_data;
                        3'd4:    opnd[4] <= pp_in_data;
                        default: ;
                    endcase
                end
                REDUCE: begin
                    // Operands 0/1 double as the running accumulator.
                    opnd[0] <= tree_s;
                    opnd[1] <= tree_h;
                    opnd[2] <= '0;
                    opnd[3] <= '0;
                    opnd[4] <= '0;
                    rem     <= rem - need;
                    first   <= 1'b0;
                    slot    <= '0;
                    if (last_pass) begin
                        res_s <= tree_s;
                        res_h <= tree_h;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PPR_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
            perf_pass  <= '0;
        end else begin
            if (state == LOAD && pp_in_ready && !pp_in_valid && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
            if (state == REDUCE && perf_pass != 16'hFFFF)
                perf_pass <= perf_pass + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pp_reduction_sequencer.sv
// Randomized bench for pp_reduction_sequencer with an order-sensitive, sum-preserving tree model.
module tb_pp_reduction_sequencer;

    typedef logic [4:0][43:0] opnd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [4:0]  req_npp;
    logic        pp_in_valid, pp_in_ready;
    logic [43:0] pp_in_data;
    logic [43:0] tree_d0, tree_d1, tree_d2, tree_d3, tree_d4;
    logic [43:0] tree_s, tree_h;
    logic        res_valid, res_ready;
    logic [43:0] res_s, res_h;
`ifdef PPR_PERF_CNT_EN
    logic [15:0] perf_stall, perf_pass;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_pass = 0;
    int exp_stall = 0;
    logic [43:0] pp_q[$];

    always #5 clk = ~clk;

    pp_reduction_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_npp(req_npp),
        .pp_in_valid(pp_in_valid), .pp_in_ready(pp_in_ready), .pp_in_data(pp_in_data),
        .tree_d0(tree_d0), .tree_d1(tree_d1), .tree_d2(tree_d2), .tree_d3(tree_d3), .tree_d4(tree_d4),
        .tree_s(tree_s), .tree_h(tree_h),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_h(res_h)
`ifdef PPR_PERF_CNT_EN
       ,.perf_stall(perf_stall), .perf_pass(perf_pass)
`endif
    );

    // Stand-in tree: S+H equals the operand sum, H depends on operand position.
    function automatic logic [87:0] tree_f(input opnd_t d);
        logic [43:0] tag, tot;
        tag = d[1] ^ (d[2] << 1) ^ (d[3] << 2) ^ (d[4] << 3);
        tot = d[0] + d[1] + d[2] + d[3] + d[4];
        return {tot - tag, tag};
    endfunction

    assign {tree_s, tree_h} = tree_f({tree_d4, tree_d3, tree_d2, tree_d1, tree_d0});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pp_ready", pp_in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_d", {tree_d0, tree_d1, tree_d2, tree_d3, tree_d4} == '0, 1);
        chk("rst_res", {res_s, res_h} == '0, 1);
`ifdef PPR_PERF_CNT_EN
        chk("rst_perf", {perf_stall, perf_pass}, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_reset();
        rst = 1'b0;
        exp_pass = 0;
        exp_stall = 0;
    endtask

    // stall_mode: 0 none, 1 every 3rd cycle, 2 random
    task automatic run_req(input int npp, input int stall_mode, input int hold);
        opnd_t       exp_d[$];
        opnd_t       d;
        logic [43:0] q[$];
        logic [43:0] s, h, gold;
        int n, idx, p, stalls, cyc;
        bit rdy, stall;
        n = (npp > 16) ? 16 : npp;
        s = '0; h = '0; gold = '0;
        for (int i = 0; i < n; i++) begin
            q.push_back(pp_q[i]);
            gold = gold + pp_q[i];
        end
        // Reference: greedy chunks of 5 then 3, accumulator carried in operands 0/1.
        if (n > 0) begin
            d = '0;
            for (int k = 0; k < 5; k++) if (q.size() > 0) d[k] = q.pop_front();
            exp_d.push_back(d);
            {s, h} = tree_f(d);
            while (q.size() > 0) begin
                d = '0; d[0] = s; d[1] = h;
                for (int k = 2; k < 5; k++) if (q.size() > 0) d[k] = q.pop_front();
                exp_d.push_back(d);
                {s, h} = tree_f(d);
            end
        end
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        req_valid = 1'b1; req_npp = npp[4:0]; res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = $urandom_range(0, 1);  // must be ignored while busy
        req_npp = 5'($urandom);
        cyc = 1; idx = 0; p = 0; stalls = 0;
        while (!res_valid && cyc < 300) begin
            rdy = pp_in_ready;
            chk("req_ready_busy", req_ready, 0);
            if (rdy) begin
                stall = (stall_mode == 1) ? (cyc % 3 == 0) :
                        (stall_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
                pp_in_valid = !stall;
                pp_in_data  = (idx < pp_q.size()) ? pp_q[idx] : 44'h0;
                if (stall) stalls++;
            end else begin
                if (p < exp_d.size()) begin
                    d = exp_d[p];
                    chk($sformatf("p%0d_d0", p), tree_d0, d[0]);
                    chk($sformatf("p%0d_d1", p), tree_d1, d[1]);
                    chk($sformatf("p%0d_d2", p), tree_d2, d[2]);
                    chk($sformatf("p%0d_d3", p), tree_d3, d[3]);
                    chk($sformatf("p%0d_d4", p), tree_d4, d[4]);
                end
                p++;
                pp_in_valid = 1'b1;           // offered but must not be consumed
                pp_in_data  = {12'hBAD, 32'($urandom)};
            end
            @(posedge clk);
            if (pp_in_valid && rdy) idx++;
            #1; cyc++;
        end
        pp_in_valid = 1'b0; req_valid = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("latency", cyc, n + exp_d.size() + 1 + stalls);
        chk("pp_count", idx, n);
        chk("passes", p, exp_d.size());
        chk("res_s", res_s, s);
        chk("res_h", res_h, h);
        chk("res_sum", 44'(res_s + res_h), gold);
        exp_pass += exp_d.size();
        exp_stall += stalls;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_res", {res_s, res_h}, {s, h});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_valid", res_valid, 0);
        chk("post_req_ready", req_ready, 1);
`ifdef PPR_PERF_CNT_EN
        chk("perf_pass", perf_pass, exp_pass);
        chk("perf_stall", perf_stall, exp_stall);
`endif
    endtask

    task automatic fill_rand();
        pp_q.delete();
        for (int i = 0; i < 20; i++) pp_q.push_back({12'($urandom), 32'($urandom)});
    endtask

    initial begin
        int idx, cyc, reduces;
        bit rdy;
        rst = 1'b1; req_valid = 0; req_npp = 0; pp_in_valid = 0; pp_in_data = 0; res_ready = 0;
        #1;
        chk_idle_reset();
        do_reset();

        // single PP
        pp_q.delete(); pp_q.push_back(44'h1); for (int i = 0; i < 19; i++) pp_q.push_back(44'h0);
        run_req(1, 0, 0);
        // one full pass, then one pass plus a partial second pass
        pp_q.delete(); for (int i = 1; i <= 20; i++) pp_q.push_back(44'(i));
        run_req(5, 0, 0);
        run_req(6, 0, 0);
        // full request with regular stalls from a clean reset
        do_reset();
        fill_rand();
        run_req(16, 1, 0);
`ifdef PPR_PERF_CNT_EN
        chk("perf_pass_16", perf_pass, 5);
`endif
        // empty request
        run_req(0, 0, 0);

        // reset during second LOAD of a 10-PP request
        fill_rand();
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1; req_npp = 5'd10;
        @(posedge clk); #1; req_valid = 0;
        idx = 0; reduces = 0; cyc = 0;
        while (idx < 6 && cyc < 40) begin
            rdy = pp_in_ready;
            if (!rdy) reduces++;
            pp_in_valid = rdy; pp_in_data = pp_q[idx];
            @(posedge clk);
            if (rdy) idx++;
            #1; cyc++;
        end
        pp_in_valid = 0;
        chk("abort_reached", idx, 6);
        chk("abort_reduces", reduces, 1);
        rst = 1'b1; #2;
        chk_idle_reset();
        @(posedge clk); #1;
        chk_idle_reset();
        rst = 1'b0; exp_pass = 0; exp_stall = 0;
        fill_rand();
        run_req(2, 0, 0);

        // output held under back-pressure, clamped request size
        fill_rand();
        run_req(16, 0, 7);
        run_req(23, 2, 1);

        for (int t = 0; t < 25; t++) begin
            fill_rand();
            run_req($urandom_range(0, 20), 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
